// File: rtl/multicycle_ctrl_if.sv
// Datapath-side bundle for the multi-cycle sequencer: decode fields, memory handshake,
// write strobes and status/perf outputs. Shared encodings are defined here.
`ifndef MULTICYCLE_CTRL_DEFS
`define MULTICYCLE_CTRL_DEFS
`define W_MEM_CMD   2
`define W_REG_SRC   1
`define W_PC_SRC    2
`define MEM_NOP     2'd0
`define MEM_READ    2'd1
`define MEM_WRITE   2'd2
`define REG_SRC_ALU 1'b0
`define REG_SRC_MEM 1'b1
`define PC_SRC_NEXT 2'd0
`define PC_SRC_BRCH 2'd1
`define PC_SRC_JUMP 2'd2
`endif

interface multicycle_ctrl_if #(
    parameter int W_CNT = 32
);
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  alu_zero;
    logic                  mem_ack;
    logic                  mem_req;
    logic [`W_MEM_CMD-1:0] mem_cmd;
    logic                  ir_wen;
    logic                  mdr_wen;
    logic                  reg_wen;
    logic [`W_REG_SRC-1:0] reg_src;
    logic                  pc_wen;
    logic [`W_PC_SRC-1:0]  pc_src;
    logic                  retire;
    logic                  halted;
    logic                  timeout_err;
    logic [W_CNT-1:0]      cycle_cnt;
    logic [W_CNT-1:0]      retire_cnt;

    modport master (
        input  opcode, funct, alu_zero, mem_ack,
        output mem_req, mem_cmd, ir_wen, mdr_wen, reg_wen, reg_src,
               pc_wen, pc_src, retire, halted, timeout_err, cycle_cnt, retire_cnt
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ack,
        input  mem_req, mem_cmd, ir_wen, mdr_wen, reg_wen, reg_src,
               pc_wen, pc_src, retire, halted, timeout_err, cycle_cnt, retire_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT over one shared memory port.
// Define MULTICYCLE_PERF_EN to build the cycle/retire performance counters.
module multicycle_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int W_CNT   = 32
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ  = 6'h04, OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW    = 6'h2b, FN_SYSCALL = 6'h0c;
    localparam int W_WD = (TIMEOUT > 0) ? $clog2(TIMEOUT + 2) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t r_state, w_next;
    logic [W_WD-1:0] r_wd;
    logic r_tmo;

    logic w_rtype, w_syscall, w_imm, w_lw, w_sw, w_beq, w_bne, w_j, w_known;
    logic w_req_st, w_expire;
    logic w_req, w_ir, w_mdr, w_reg, w_pcw, w_ret;
    logic [`W_MEM_CMD-1:0] w_cmd;
    logic [`W_REG_SRC-1:0] w_rsrc;
    logic [`W_PC_SRC-1:0]  w_psrc;

    assign w_rtype   = (bus.opcode == OP_RTYPE);
    assign w_syscall = w_rtype && (bus.funct == FN_SYSCALL);
    assign w_imm     = bus.opcode inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI};
    assign w_lw      = (bus.opcode == OP_LW);
    assign w_sw      = (bus.opcode == OP_SW);
    assign w_beq     = (bus.opcode == OP_BEQ);
    assign w_bne     = (bus.opcode == OP_BNE);
    assign w_j       = (bus.opcode == OP_J);
    assign w_known   = w_rtype | w_imm | w_lw | w_sw | w_beq | w_bne | w_j;

    // A request may wait TIMEOUT cycles beyond its first; the cycle after that expires.
    assign w_req_st = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_expire = (TIMEOUT != 0) && w_req_st && !bus.mem_ack && (r_wd == W_WD'(TIMEOUT + 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wd    <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (TIMEOUT == 0 || !w_req_st || bus.mem_ack || w_next != r_state)
                r_wd <= '0;
            else
                r_wd <= r_wd + W_WD'(1);
            if (w_expire)
                r_tmo <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_cmd  = `MEM_NOP;
        w_ir   = 1'b0;
        w_mdr  = 1'b0;
        w_reg  = 1'b0;
        w_rsrc = `REG_SRC_ALU;
        w_pcw  = 1'b0;
        w_psrc = `PC_SRC_NEXT;
        w_ret  = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                w_req = 1'b1;
                w_cmd = `MEM_READ;
                if (bus.mem_ack) begin
                    w_ir   = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_known) begin
                    w_pcw  = 1'b1;
                    w_ret  = 1'b1;
                    w_next = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_syscall) begin
                    w_ret  = 1'b1;
                    w_next = S_HALT;
                end else if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else if (w_beq || w_bne) begin
                    w_pcw  = 1'b1;
                    w_ret  = 1'b1;
                    w_psrc = ((w_beq && bus.alu_zero) || (w_bne && !bus.alu_zero)) ? `PC_SRC_BRCH : `PC_SRC_NEXT;
                    w_next = S_FETCH;
                end else if (w_j) begin
                    w_pcw  = 1'b1;
                    w_ret  = 1'b1;
                    w_psrc = `PC_SRC_JUMP;
                    w_next = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_req = 1'b1;
                w_cmd = w_lw ? `MEM_READ : `MEM_WRITE;
                if (bus.mem_ack) begin
                    if (w_lw) begin
                        w_mdr  = 1'b1;
                        w_next = S_WB;
                    end else begin
                        w_pcw  = 1'b1;
                        w_ret  = 1'b1;
                        w_next = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_reg  = 1'b1;
                w_rsrc = w_lw ? `REG_SRC_MEM : `REG_SRC_ALU;
                w_pcw  = 1'b1;
                w_ret  = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
        // Expiry only happens without ack, so no strobe needs cancelling here.
        if (w_expire) begin
            w_next = S_HALT;
            w_req  = 1'b0;
            w_cmd  = `MEM_NOP;
        end
    end

    assign bus.mem_req     = w_req;
    assign bus.mem_cmd     = w_cmd;
    assign bus.ir_wen      = w_ir;
    assign bus.mdr_wen     = w_mdr;
    assign bus.reg_wen     = w_reg;
    assign bus.reg_src     = w_rsrc;
    assign bus.pc_wen      = w_pcw;
    assign bus.pc_src      = w_psrc;
    assign bus.retire      = w_ret;
    assign bus.halted      = (r_state == S_HALT) || w_expire;
    assign bus.timeout_err = r_tmo || w_expire;

`ifdef MULTICYCLE_PERF_EN
    logic [W_CNT-1:0] r_cycle_cnt, r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + W_CNT'(1);
            if (w_ret)
                r_retire_cnt <= r_retire_cnt + W_CNT'(1);
        end
    end

    assign bus.cycle_cnt  = r_cycle_cnt;
    assign bus.retire_cnt = r_retire_cnt;
`else
    assign bus.cycle_cnt  = '0;
    assign bus.retire_cnt = '0;
`endif
endmodule
